// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : Shared types and opcode constants for the immediate generator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

    typedef enum logic [2:0] {
        IMM_R   = 3'd0,
        IMM_I   = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_ILL = 3'd7
    } imm_type_e;

    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_system = 7'b1110011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    localparam logic [2:0] c_f3_sll = 3'b001;
    localparam logic [2:0] c_f3_srx = 3'b101;

endpackage : imm_pkg

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module      : imm_decode
// Description : Combinational opcode decode and immediate sign/zero extension.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;
    logic            w_is_shift;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];

    assign w_imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign w_imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                      inst[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                      inst[30:21], 1'b0};

    // Shift amount width follows XLEN; funct7 bits never leak into the result.
    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_shamt = {{(XLEN-6){1'b0}}, inst[25:20]};
        end else begin : g_shamt32
            assign w_shamt = {{(XLEN-5){1'b0}}, inst[24:20]};
        end
    endgenerate

    assign w_is_shift = (w_opcode == c_opc_op_imm) &&
                        ((w_funct3 == c_f3_sll) || (w_funct3 == c_f3_srx));

    always_comb begin
        imm      = '0;
        imm_type = IMM_ILL;
        illegal  = 1'b0;
        case (w_opcode)
            c_opc_load, c_opc_op_imm, c_opc_jalr, c_opc_system: begin
                imm_type = IMM_I;
                imm      = w_is_shift ? w_shamt : w_imm_i;
            end
            c_opc_store: begin
                imm_type = IMM_S;
                imm      = w_imm_s;
            end
            c_opc_branch: begin
                imm_type = IMM_B;
                imm      = w_imm_b;
            end
            c_opc_lui, c_opc_auipc: begin
                imm_type = IMM_U;
                imm      = w_imm_u;
            end
            c_opc_jal: begin
                imm_type = IMM_J;
                imm      = w_imm_j;
            end
            c_opc_op: begin
                imm_type = IMM_R;
            end
            default: begin
                imm_type = IMM_ILL;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule : imm_decode

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Immediate generator behind a 2-entry main/skid elastic buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0]  w_dec_imm;
    imm_type_e        w_dec_type;
    logic             w_dec_ill;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_type;
    logic             r_main_ill;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_type;
    logic             r_skid_ill;

    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_fire;
    logic             w_main_free;
    logic             w_skid_next;

    imm_decode #(
        .XLEN     (XLEN)
    ) u_decode (
        .inst     (inst),
        .imm      (w_dec_imm),
        .imm_type (w_dec_type),
        .illegal  (w_dec_ill)
    );

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_main_free = ~r_main_valid | out_ready;
    // in_ready is only high while the skid is empty, so a skid refill never
    // coincides with the skid draining into main.
    assign w_skid_next = w_main_free ? 1'b0 : (r_skid_valid | w_in_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_type  <= 3'd0;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= 3'd0;
            r_skid_ill   <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_imm   <= r_skid_imm;
                    r_main_type  <= r_skid_type;
                    r_main_ill   <= r_skid_ill;
                end else if (w_in_fire) begin
                    r_main_valid <= 1'b1;
                    r_main_imm   <= w_dec_imm;
                    r_main_type  <= w_dec_type;
                    r_main_ill   <= w_dec_ill;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_imm   <= w_dec_imm;
                r_skid_type  <= w_dec_type;
                r_skid_ill   <= w_dec_ill;
            end
            r_skid_valid <= w_skid_next;
            r_in_ready   <= ~w_skid_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_in_fire && w_dec_ill && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign imm_out     = r_main_imm;
    assign imm_type    = r_main_type;
    assign illegal     = r_main_ill;
    assign illegal_cnt = r_cnt;

endmodule : imm_gen_pipe

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe (XLEN=32 main, XLEN=64 aux).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] inst, imm_out;
    logic [2:0]  imm_type;
    logic [15:0] illegal_cnt;

    logic        in_valid64, in_ready64, out_valid64, illegal64;
    logic [31:0] inst64;
    logic [63:0] imm_out64;
    logic [2:0]  imm_type64;
    logic [15:0] illegal_cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .imm_type(imm_type), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst(inst64), .out_valid(out_valid64), .out_ready(1'b1),
        .imm_out(imm_out64), .imm_type(imm_type64), .illegal(illegal64),
        .illegal_cnt(illegal_cnt64)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL extra_out: observed imm=%h with empty scoreboard", imm_out);
            end else begin
                mon_e = sb.pop_front();
                chk("out_imm", {32'd0, imm_out}, {32'd0, mon_e.imm});
                chk("out_type_ill", {60'd0, imm_type, illegal}, {60'd0, mon_e.typ, mon_e.ill});
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] eimm,
                        input logic [2:0] et, input logic ei);
        inst     = i;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({eimm, et, ei});
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $error("FAIL send_timeout: observed in_ready=0 expected 1 for inst %h", i);
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = '0; out_ready = 1'b1;
        in_valid64 = 1'b0; inst64 = '0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_imm", {32'd0, imm_out}, 64'd0);
        chk("rst_type_ill", {60'd0, imm_type, illegal}, 64'd0);
        chk("rst_cnt", {48'd0, illegal_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Decode and one-cycle latency
        send(32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0);
        in_valid = 1'b0;
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        chk("latency_imm", {32'd0, imm_out}, {32'd0, 32'hFFFFFFFC});
        send(32'hFE112FA3, 32'hFFFFFFFF, 3'd2, 1'b0);
        send(32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0);
        send(32'h41F0D093, 32'h0000001F, 3'd1, 1'b0);
        send(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
        send(32'h002081B3, 32'h00000000, 3'd0, 1'b0);
        send(32'h12345037, 32'h12345000, 3'd4, 1'b0);
        send(32'h7FF00093, 32'h000007FF, 3'd1, 1'b0);
        in_valid = 1'b0;
        drain();

        // XLEN=64 U-type
        inst64 = 32'h800000B7;
        in_valid64 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready64) break;
        end
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        chk("x64_valid", {63'd0, out_valid64}, 64'd1);
        chk("x64_imm", imm_out64, 64'hFFFFFFFF80000000);
        chk("x64_type", {60'd0, imm_type64, illegal64}, {60'd0, 3'd4, 1'b0});
        chk("x64_cnt", {48'd0, illegal_cnt64}, 64'd0);

        // Illegal path and counter saturation
        chk("cnt_before_ill", {48'd0, illegal_cnt}, 64'd0);
        send(32'h0000007F, 32'h0, 3'd7, 1'b1);
        in_valid = 1'b0;
        chk("ill_flag", {63'd0, illegal}, 64'd1);
        chk("cnt_after_ill", {48'd0, illegal_cnt}, 64'd1);
        for (int n = 0; n < 65534; n++) send(32'h0000007F, 32'h0, 3'd7, 1'b1);
        in_valid = 1'b0;
        chk("cnt_full", {48'd0, illegal_cnt}, 64'h000000000000FFFF);
        send(32'h0000007F, 32'h0, 3'd7, 1'b1);
        in_valid = 1'b0;
        chk("cnt_saturated", {48'd0, illegal_cnt}, 64'h000000000000FFFF);
        drain();

        // Backpressure: two accepted, third held, then released gap-free
        out_ready = 1'b0;
        send(32'h00100093, 32'h1, 3'd1, 1'b0);
        send(32'h00200093, 32'h2, 3'd1, 1'b0);
        inst = 32'h00300093;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_hold", {31'd0, out_valid, imm_out}, {31'd0, 1'b1, 32'h1});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_gap", {63'd0, out_valid}, 64'd1);
            if (k == 0) chk("bp_ready_still_low", {63'd0, in_ready}, 64'd0);
            if (k == 1) begin
                chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
                sb.push_back({32'h3, 3'd1, 1'b0});
            end
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
        end
        drain();

        // Reset with both entries full
        out_ready = 1'b0;
        send(32'h00400093, 32'h4, 3'd1, 1'b0);
        send(32'h00500093, 32'h5, 3'd1, 1'b0);
        in_valid = 1'b0;
        chk("full_before_rst", {62'd0, out_valid, in_ready}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_cnt", {48'd0, illegal_cnt}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_output", {63'd0, out_valid}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_gen_pipe

`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning inst is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts inst this cycle.
REQ-007 SHALL have port inst, input, 32, the instruction word.
REQ-008 SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port imm_out, output, XLEN, the extended immediate.
REQ-011 SHALL have port imm_type, output, 3, the decoded format code.
REQ-012 SHALL have port illegal, output, 1, meaning the opcode is unsupported.
REQ-013 SHALL have port illegal_cnt, output, CNT_W, a saturating count of illegal instructions accepted.

Function
REQ-014 SHALL decode opcode inst[6:0] as follows:
- I: 0000011, 0010011, 1100111, 1110011
- S: 0100011
- B: 1100011
- U: 0110111, 0010111
- J: 1101111
- R: 0110011
- any other value: ILL.
REQ-015 SHALL form the immediates as follows, each sign-extended from inst[31] to XLEN:
- I = inst[31:20]
- S = {inst[31:25],inst[11:7]}
- B = {inst[31],inst[7],inst[30:25],inst[11:8],0}
- U = {inst[31:12],12'b0}
- J = {inst[31],inst[19:12],inst[20],inst[30:21],0}
REQ-016 SHALL, for opcode 0010011 with funct3 001 or 101, output a zero-extended shamt instead: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64. funct7 bits are excluded.
REQ-017 SHALL output imm_out=0 for R and ILL, with illegal=1 only for ILL.
REQ-018 SHALL register results; minimum latency is one cycle, from the accepting edge to out_valid=1.
REQ-019 SHALL implement a 2-entry elastic buffer consisting of a main register and a skid register.
REQ-020 SHALL drive in_ready registered, equal to "skid register empty"; it SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL treat a transfer as occurring on valid&ready at each port.
REQ-022 SHALL hold out_valid and the data stable until out_ready=1.
REQ-023 SHALL, on simultaneous input and output transfer with the skid register empty, load the new result into the main register with no bubble.
REQ-024 SHALL, when the main register is stalled and an input transfer occurs, store the result in the skid register; in_ready falls the next cycle.
REQ-025 SHALL, when the main register drains while the skid register is full, move the skid entry to the main register and raise in_ready the next cycle.
REQ-026 SHALL preserve input order; results are never dropped or duplicated.
REQ-027 SHALL increment illegal_cnt by one at input acceptance of each ILL instruction, saturating at all-ones.

Reset
REQ-028 SHALL, while rst=1, clear the following asynchronously:
- out_valid=0, in_ready=0
- imm_out=0, imm_type=0, illegal=0
- illegal_cnt=0
- both buffer entries empty.
REQ-029 SHALL drive in_ready=1 on the first clk edge after rst deasserts.
REQ-030 SHALL discard any in-flight results on reset mid-operation; nothing is presented after release.

Structure
REQ-031 SHALL take the following from shared package imm_pkg:
- imm_type_e: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
- opcode localparams.
REQ-032 SHALL place decode and extension in combinational sub-module imm_decode (inst in; imm, type, illegal out; parameter XLEN). imm_gen_pipe owns the buffer and the counter.

Verification
REQ-033 SHALL verify decoding with out_ready=1 and XLEN=32:
- 0xFFC12083 -> imm_out 0xFFFFFFFC, type I, one cycle later
- 0xFE112FA3 -> 0xFFFFFFFF, type S
- 0xFF9FF06F -> 0xFFFFFFF8, type J.
REQ-034 SHALL verify the shamt path with XLEN=32: 0x41F0D093 (srai) -> 0x0000001F.
REQ-035 SHALL verify U-type extension with XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-036 SHALL verify backpressure: hold out_ready=0 while offering three instructions back-to-back.
- Two are accepted and in_ready=0.
- The third is held.
- Releasing out_ready yields all three in order, with no gaps.
REQ-037 SHALL verify the illegal path: 0x0000007F -> illegal=1, imm 0, illegal_cnt 0->1. Preloading illegal_cnt at 0xFFFF and sending one more illegal instruction leaves it at 0xFFFF.
REQ-038 SHALL verify reset mid-operation: assert rst with both entries full.
- out_valid drops without waiting for a clock edge.
- illegal_cnt=0.
- in_ready=1 one edge after release.
